// File: rtl/decode_pkg.sv
// decode_pkg: shared types, RISC-V opcodes and format lookup for the decode stage
package decode_pkg;

    localparam int MAX_XLEN = 64;
    localparam int MAX_PC_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    // Entry is sized for the widest configuration; narrower builds drop the upper bits at the output.
    typedef struct packed {
        logic [MAX_PC_W-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        fmt_e                fmt;
        logic [MAX_XLEN-1:0] imm;
        logic                illegal;
    } dec_entry_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP:                                    return FMT_R;
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:  return FMT_I;
            STORE:                                 return FMT_S;
            BRANCH:                                return FMT_B;
            LUI, AUIPC:                            return FMT_U;
            JAL:                                   return FMT_J;
            default:                               return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and issue-side handshake bundle of the decode stage
interface decode_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    fmt_e            out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_fmt, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_fmt, out_imm, out_illegal
    );
endinterface

// File: rtl/decode_skid.sv
// decode_skid: two-entry skid buffer with registered in_ready, FIFO order, flush
module decode_skid #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e r_state;
    state_e w_next;
    T       r_main;
    T       r_skid;
    logic   r_in_ready;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_skid_to_main;

    assign w_in_fire  = i_valid & r_in_ready;
    assign w_out_fire = (r_state != EMPTY) & i_ready;

    // Next state and which entry register loads; flush overrides everything.
    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (i_flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_next      = w_in_fire ? ONE : EMPTY;
                    w_load_main = w_in_fire;
                end
                ONE: begin
                    w_next      = w_in_fire ? (w_out_fire ? ONE : TWO) : (w_out_fire ? EMPTY : ONE);
                    w_load_main = w_in_fire & w_out_fire;
                    w_load_skid = w_in_fire & !w_out_fire;
                end
                TWO: begin
                    w_next         = w_out_fire ? ONE : TWO;
                    w_skid_to_main = w_out_fire;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // State, registered ready and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
            if (w_load_main)
                r_main <= i_data;
            else if (w_skid_to_main)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= i_data;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = (r_state != EMPTY);
    assign o_data  = r_main;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode with format/immediate select and skid buffer.
// Optional DECODE_ILLEGAL_CHECK_EN enables the illegal-instruction flag.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input logic     clk,
    input logic     rst_n,
    input logic     flush,
    decode_if.slave bus
);
    logic [31:0] w_i;
    logic [6:0]  w_op;
    fmt_e        w_fmt;
    logic [31:0] w_imm32;
    logic        w_illegal;
    dec_entry_t  w_entry;
    dec_entry_t  w_out;
    logic        w_unused;

    assign w_i   = bus.in_instr;
    assign w_op  = w_i[6:0];
    assign w_fmt = fmt_of(w_op);

    assign w_imm32 = (w_fmt == FMT_I) ? {{20{w_i[31]}}, w_i[31:20]} :
                     (w_fmt == FMT_S) ? {{20{w_i[31]}}, w_i[31:25], w_i[11:7]} :
                     (w_fmt == FMT_B) ? {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
                     (w_fmt == FMT_U) ? {w_i[31:12], 12'd0} :
                     (w_fmt == FMT_J) ? {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} :
                     32'd0;

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign w_illegal = (w_i[1:0] != 2'b11)
                     | (w_fmt == FMT_NONE)
                     | ((w_op == BRANCH) & (w_i[14:13] == 2'b01))
                     | ((w_op == OP) & (w_i[31:25] != 7'b0000000) & (w_i[31:25] != 7'b0100000))
                     | ((XLEN == 32) & (w_op == OP_IMM) & (w_i[13:12] == 2'b01) & w_i[25]);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_entry = '{
        pc:      MAX_PC_W'(bus.in_pc),
        opcode:  w_op,
        rd:      w_i[11:7],
        rs1:     w_i[19:15],
        rs2:     w_i[24:20],
        funct3:  w_i[14:12],
        funct7:  w_i[31:25],
        fmt:     w_fmt,
        imm:     {{(MAX_XLEN-32){w_imm32[31]}}, w_imm32},
        illegal: w_illegal
    };

    decode_skid #(.T(dec_entry_t)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_entry),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out)
    );

    assign bus.out_pc      = w_out.pc[PC_W-1:0];
    assign bus.out_opcode  = w_out.opcode;
    assign bus.out_rd      = w_out.rd;
    assign bus.out_rs1     = w_out.rs1;
    assign bus.out_rs2     = w_out.rs2;
    assign bus.out_funct3  = w_out.funct3;
    assign bus.out_funct7  = w_out.funct7;
    assign bus.out_fmt     = w_out.fmt;
    assign bus.out_imm     = w_out.imm[XLEN-1:0];
    assign bus.out_illegal = w_out.illegal;

    // Upper pc/imm bits beyond PC_W/XLEN are carried in the entry but never driven out.
    assign w_unused = ^w_out;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage at XLEN=32 and XLEN=64 (honours DECODE_ILLEGAL_CHECK_EN)
module tb_decode_stage;
    import decode_pkg::*;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decode_if #(.XLEN(32), .PC_W(32)) if32 ();
    decode_if #(.XLEN(64), .PC_W(32)) if64 ();

    decode_stage #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave));
    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave));

    assign if64.in_valid  = if32.in_valid;
    assign if64.in_instr  = if32.in_instr;
    assign if64.in_pc     = if32.in_pc;
    assign if64.out_ready = if32.out_ready;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if32.in_valid = v;
        if32.in_instr = instr;
        if32.in_pc    = pc;
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0);
        if32.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", if32.in_ready, 1);
        chk("rst_out_valid", if32.out_valid, 0);
        chk("rst_fmt", if32.out_fmt, FMT_NONE);
        chk("rst_imm", if32.out_imm, 0);
        chk("rst_imm64", if64.out_imm, 0);
        chk("rst_rd", if32.out_rd, 0);
        chk("rst_pc", if32.out_pc, 0);
        chk("rst_illegal", if32.out_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        if32.out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        chk("addi_valid", if32.out_valid, 1);
        chk("addi_rd", if32.out_rd, 1);
        chk("addi_rs1", if32.out_rs1, 0);
        chk("addi_fmt", if32.out_fmt, FMT_I);
        chk("addi_imm", if32.out_imm, 64'hFFFFFFFF);
        chk("addi_imm64", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_pc", if32.out_pc, 32'h100);
        chk("addi_opcode", if32.out_opcode, 7'h13);
        chk("addi_illegal", if32.out_illegal, 0);
        chk("addi_in_ready", if32.in_ready, 1);

        drive(1'b1, 32'hFE000EE3, 32'h104);
        tick();
        chk("beq_fmt", if32.out_fmt, FMT_B);
        chk("beq_imm", if32.out_imm, 64'hFFFFFFFC);
        chk("beq_funct3", if32.out_funct3, 0);
        chk("beq_funct7", if32.out_funct7, 7'h7F);
        chk("beq_pc", if32.out_pc, 32'h104);

        drive(1'b1, 32'h800002B7, 32'h108);
        tick();
        chk("lui_fmt", if64.out_fmt, FMT_U);
        chk("lui_rd", if64.out_rd, 5);
        chk("lui_imm64", if64.out_imm, 64'hFFFFFFFF80000000);
        chk("lui_imm32", if32.out_imm, 64'h80000000);

        drive(1'b1, 32'h0020A423, 32'h10C);
        tick();
        chk("sw_fmt", if32.out_fmt, FMT_S);
        chk("sw_imm", if32.out_imm, 8);
        chk("sw_rs1", if32.out_rs1, 1);
        chk("sw_rs2", if32.out_rs2, 2);
        chk("sw_funct3", if32.out_funct3, 2);

        drive(1'b1, 32'h0080006F, 32'h110);
        tick();
        chk("jal_fmt", if32.out_fmt, FMT_J);
        chk("jal_imm", if32.out_imm, 8);

        drive(1'b1, 32'h002081B3, 32'h114);
        tick();
        chk("add_fmt", if32.out_fmt, FMT_R);
        chk("add_imm", if32.out_imm, 0);
        chk("add_rd", if32.out_rd, 3);
        chk("add_illegal", if32.out_illegal, 0);

        drive(1'b1, 32'h00000000, 32'h118);
        tick();
        chk("zero_fmt", if32.out_fmt, FMT_NONE);
        chk("zero_imm", if32.out_imm, 0);
        chk("zero_illegal", if32.out_illegal, EXP_ILL);

        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", if32.out_valid, 0);

        if32.out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h200);
        tick();
        chk("bp_a_valid", if32.out_valid, 1);
        chk("bp_a_rd", if32.out_rd, 2);
        chk("bp_a_ready", if32.in_ready, 1);
        drive(1'b1, 32'h00200193, 32'h204);
        tick();
        chk("bp_b_ready", if32.in_ready, 0);
        chk("bp_b_rd_held", if32.out_rd, 2);
        drive(1'b1, 32'h00300213, 32'h208);
        tick();
        chk("bp_c_ready", if32.in_ready, 0);
        chk("bp_c_rd_held", if32.out_rd, 2);
        chk("bp_c_pc_held", if32.out_pc, 32'h200);
        if32.out_ready = 1'b1;
        tick();
        chk("bp_out_b_rd", if32.out_rd, 3);
        chk("bp_out_b_pc", if32.out_pc, 32'h204);
        chk("bp_out_b_ready", if32.in_ready, 1);
        tick();
        chk("bp_out_c_rd", if32.out_rd, 4);
        chk("bp_out_c_pc", if32.out_pc, 32'h208);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_empty", if32.out_valid, 0);

        if32.out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h300);
        tick();
        drive(1'b1, 32'h00200193, 32'h304);
        tick();
        chk("fl_two_ready", if32.in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'h00300213, 32'h308);
        tick();
        flush = 1'b0;
        chk("fl_two_valid", if32.out_valid, 0);
        chk("fl_two_ready1", if32.in_ready, 1);
        drive(1'b0, 32'h0, 32'h0);
        if32.out_ready = 1'b1;
        tick();
        chk("fl_two_stays_empty", if32.out_valid, 0);

        if32.out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h400);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h00200193, 32'h404);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_one_valid", if32.out_valid, 0);
        tick();
        chk("fl_one_stays_empty", if32.out_valid, 0);

        drive(1'b1, 32'h00100113, 32'h500);
        tick();
        drive(1'b1, 32'h00200193, 32'h504);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", if32.out_valid, 0);
        chk("arst_ready", if32.in_ready, 1);
        chk("arst_rd", if32.out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_after_valid", if32.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
